dot_matrix_scheduler: RTL
=========================

DOT_MATRIX_SCHEDULER -- requirements
Module: dot_matrix_scheduler

Interface
REQ-001 Parameter SCAN_DIV, default 4, clocks per row slot (>=1).
REQ-002 Parameter BLINK_FRAMES, default 4, frames per blink half-period (>=1).
REQ-003 Parameter EVENT_BLINKS, default 3, blink periods per car-event announcement (>=1).
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 power  input  1  display power; 0 blanks and halts scanning.
REQ-007 free_cnt  input  4  free parking spaces to display.
REQ-008 car_in  input  1  one-cycle pulse, car entered.
REQ-009 car_out  input  1  one-cycle pulse, car left.
REQ-010 scan_cnt  output  3  active matrix row index to DotMatrix.
REQ-011 enable  output  1  display enable to DotMatrix.
REQ-012 num  output  4  digit to DotMatrix, range 0..9.
REQ-013 busy  output  1  high while announcing (ANNOUNCE state).

Function
REQ-014 Prescaler div_cnt SHALL count 0..SCAN_DIV-1 while power=1; scan_cnt SHALL increment, wrapping 7->0, on the cycle div_cnt wraps.
REQ-015 frame_tick SHALL be asserted internally for the single cycle where div_cnt=SCAN_DIV-1 and scan_cnt=7; one frame = 8*SCAN_DIV clocks.
REQ-016 num SHALL update only on frame_tick (no mid-frame tearing), loading free_cnt, clamped to 9 when free_cnt>9.
REQ-017 FSM states SHALL be OFF, SHOW, ANNOUNCE, FULL.
REQ-018 Any state with power=0 -> OFF next cycle; in OFF: enable=0, div_cnt=0, scan_cnt=0, busy=0, num held.
REQ-019 OFF with power=1 -> SHOW next cycle; num SHALL load clamped free_cnt on that transition.
REQ-020 SHOW: enable=1; car_in or car_out -> ANNOUNCE; else free_cnt=0 sampled on frame_tick -> FULL.
REQ-021 ANNOUNCE: blink counter resets on entry; enable=0 for first BLINK_FRAMES frames, 1 for next BLINK_FRAMES frames, repeated EVENT_BLINKS times; then on that frame_tick -> FULL if free_cnt=0, else SHOW.
REQ-022 car_in/car_out during ANNOUNCE SHALL restart the announcement (blink counter to 0, enable=0 from next cycle).
REQ-023 car_in and car_out in the same cycle SHALL count as one event.
REQ-024 FULL: enable toggles every BLINK_FRAMES frames, starting 0, indefinitely; on frame_tick with free_cnt!=0 -> SHOW; a car event -> ANNOUNCE (event priority over FULL exit).
REQ-025 Blink phase changes SHALL occur only on frame_tick; enable transitions in blink states are frame-aligned.
REQ-026 Scanning SHALL continue in SHOW, ANNOUNCE, FULL regardless of enable.

Reset
REQ-027 rst_n=0 SHALL immediately force state=OFF, div_cnt=0, scan_cnt=0, enable=0, num=0, busy=0, blink counters 0.
REQ-028 Reset asserted mid-announcement SHALL discard the event; after release FSM proceeds per REQ-019.
REQ-029 Event pulses while rst_n=0 or power=0 SHALL be ignored.

Verification (SCAN_DIV=2, BLINK_FRAMES=1, EVENT_BLINKS=2; frame=16 clocks)
REQ-030 Release reset, power=1, free_cnt=5 -> SHOW, enable=1, num=5, scan_cnt steps 0..7 every 2 clocks, wraps to 0.
REQ-031 In SHOW pulse car_in -> busy=1, enable=0 for 16 clocks, 1 for 16, 0 for 16, 1 for 16, then SHOW, busy=0.
REQ-032 free_cnt 5->0 mid-frame -> num stays 5 until frame_tick, then num=0, FULL, enable toggles every 16 clocks; free_cnt=1 -> SHOW at next frame_tick, num=1.
REQ-033 car_in and car_out same cycle, second car_out 20 clocks later -> single announcement restarted at second pulse, 64 clocks long from it.
REQ-034 free_cnt=12 -> num=9; power=0 mid-frame -> next cycle enable=0, scan_cnt=0, busy=0.
REQ-035 rst_n=0 during ANNOUNCE -> all outputs 0 asynchronously; after release with power=1 -> SHOW, no residual blinking.

Source files
------------

// File: rtl/dot_matrix_scheduler_if.sv
// Signal bundle between the parking controller and the dot-matrix display scheduler.
// The master drives power/occupancy/car events; the slave returns scan/enable/digit/busy.
interface dot_matrix_scheduler_if;
    logic       power;
    logic [3:0] free_cnt;
    logic       car_in;
    logic       car_out;
    logic [2:0] scan_cnt;
    logic       enable;
    logic [3:0] num;
    logic       busy;

    modport master (
        output power, free_cnt, car_in, car_out,
        input  scan_cnt, enable, num, busy
    );

    modport slave (
        input  power, free_cnt, car_in, car_out,
        output scan_cnt, enable, num, busy
    );
endinterface

// File: rtl/dot_matrix_scheduler.sv
// Row-scan, digit latch and blink scheduler for the free-space dot-matrix sign.
// Digit and blink phase only change on frame boundaries so the matrix never tears.
module dot_matrix_scheduler #(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned BLINK_FRAMES = 4,
    parameter int unsigned EVENT_BLINKS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dot_matrix_scheduler_if.slave   bus
);
    localparam int unsigned DW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned HW = $clog2(2 * EVENT_BLINKS);

    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(2 * EVENT_BLINKS - 1);

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        SHOW     = 2'd1,
        ANNOUNCE = 2'd2,
        FULL     = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [DW-1:0] div_cnt;
    logic [2:0]    scan_cnt;
    logic [3:0]    num;
    logic [FW-1:0] frame_cnt;
    logic [HW-1:0] half_cnt;
    logic          phase;

    logic          scanning;
    logic          frame_tick;
    logic          car_event;
    logic          announce_done;
    logic          blink_clear;
    logic          blink_state;
    logic          enable_d;
    logic          busy_d;
    logic [3:0]    free_clamped;

    assign scanning      = bus.power && (state != OFF);
    assign frame_tick    = scanning && (div_cnt == DIV_LAST) && (scan_cnt == 3'd7);
    assign car_event     = bus.power && (bus.car_in || bus.car_out);
    assign announce_done = frame_tick && (frame_cnt == FRAME_LAST) && (half_cnt == HALF_LAST);
    assign free_clamped  = (bus.free_cnt > 4'd9) ? 4'd9 : bus.free_cnt;
    assign blink_state   = (state == ANNOUNCE) || (state == FULL);

    // Any state change, and any event seen while announcing, restarts the blink sequence.
    assign blink_clear   = (state_next != state) || ((state == ANNOUNCE) && car_event);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        enable_d   = 1'b0;
        busy_d     = 1'b0;
        if (!bus.power) begin
            state_next = OFF;
        end else begin
            unique case (state)
                OFF: state_next = SHOW;
                SHOW: begin
                    if (car_event) begin
                        state_next = ANNOUNCE;
                    end else if (frame_tick && (bus.free_cnt == 4'd0)) begin
                        state_next = FULL;
                    end
                end
                ANNOUNCE: begin
                    if (car_event) begin
                        state_next = ANNOUNCE;
                    end else if (announce_done) begin
                        state_next = (bus.free_cnt == 4'd0) ? FULL : SHOW;
                    end
                end
                FULL: begin
                    if (car_event) begin
                        state_next = ANNOUNCE;
                    end else if (frame_tick && (bus.free_cnt != 4'd0)) begin
                        state_next = SHOW;
                    end
                end
                default: state_next = OFF;
            endcase
        end

        unique case (state)
            SHOW:     enable_d = 1'b1;
            ANNOUNCE: begin
                enable_d = phase;
                busy_d   = 1'b1;
            end
            FULL:     enable_d = phase;
            default:  enable_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            scan_cnt <= '0;
        end else if (!scanning) begin
            div_cnt  <= '0;
            scan_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            scan_cnt <= scan_cnt + 3'd1;
        end else begin
            div_cnt  <= div_cnt + DW'(1);
        end
    end

    // Digit is loaded at power-up and otherwise only at frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num <= '0;
        end else if (((state == OFF) && bus.power) || frame_tick) begin
            num <= free_clamped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            half_cnt  <= '0;
            phase     <= 1'b0;
        end else if (blink_clear) begin
            frame_cnt <= '0;
            half_cnt  <= '0;
            phase     <= 1'b0;
        end else if (frame_tick && blink_state) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                half_cnt  <= half_cnt + HW'(1);
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    assign bus.scan_cnt = scan_cnt;
    assign bus.num      = num;
    assign bus.enable   = enable_d;
    assign bus.busy     = busy_d;
endmodule
